// File: rtl/multi_cycle_mips_control_fsm_pkg.sv
// Shared opcodes, state encoding and control-vector layout for the multi-cycle MIPS controller.
// Optional MIPS_PERF_CNT_EN adds cycle/retired-instruction counters (see top and interface).
package mips_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU     = 2'b00;
  localparam logic [1:0] PC_SRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_t;

  // Raw per-state controls; mem_gated marks states whose enables wait on MEM_READY.
  typedef struct packed {
    logic       ior_d;
    logic       ir_wr;
    logic       pc_write;
    logic       branch;
    logic       mem_wr;
    logic       rf_wr;
    logic       wd3_sel;
    logic       a3_sel;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       done;
    logic       mem_gated;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_mips_control_fsm_if.sv
// Controller <-> datapath control bundle; master is the controller side.
// MIPS_PERF_CNT_EN adds the CYCLE_COUNT / INSTR_RETIRED outputs.
interface multi_cycle_mips_control_fsm_if #(
  parameter int OPC_WIDTH = 6
);
  logic [OPC_WIDTH-1:0] OP_CODE;
  logic                 ZERO;
  logic                 MEM_READY;
  logic                 PC_EN;
  logic                 IOR_D_SEL;
  logic                 IR_WR_EN;
  logic                 DATA_MEM_WR_EN;
  logic                 REG_FILE_WR_EN;
  logic                 REG_FILE_WD3_SEL;
  logic                 REG_FILE_A3_SEL;
  logic                 ALU_SRC_A_SEL;
  logic [1:0]           ALU_SRC_B_SEL;
  logic [1:0]           ALU_OP;
  logic [1:0]           PC_SRC_SEL;
  logic                 INSTR_DONE;
  logic                 ILLEGAL_OP;
`ifdef MIPS_PERF_CNT_EN
  logic [31:0]          CYCLE_COUNT;
  logic [31:0]          INSTR_RETIRED;
`endif

  modport master (
    input  OP_CODE, ZERO, MEM_READY,
    output PC_EN, IOR_D_SEL, IR_WR_EN, DATA_MEM_WR_EN, REG_FILE_WR_EN,
           REG_FILE_WD3_SEL, REG_FILE_A3_SEL, ALU_SRC_A_SEL, ALU_SRC_B_SEL,
           ALU_OP, PC_SRC_SEL, INSTR_DONE, ILLEGAL_OP
`ifdef MIPS_PERF_CNT_EN
    , output CYCLE_COUNT, INSTR_RETIRED
`endif
  );

  modport slave (
    output OP_CODE, ZERO, MEM_READY,
    input  PC_EN, IOR_D_SEL, IR_WR_EN, DATA_MEM_WR_EN, REG_FILE_WR_EN,
           REG_FILE_WD3_SEL, REG_FILE_A3_SEL, ALU_SRC_A_SEL, ALU_SRC_B_SEL,
           ALU_OP, PC_SRC_SEL, INSTR_DONE, ILLEGAL_OP
`ifdef MIPS_PERF_CNT_EN
    , input CYCLE_COUNT, INSTR_RETIRED
`endif
  );
endinterface

// File: rtl/multi_cycle_mips_control_fsm_out_decode.sv
// Pure state -> raw control-vector lookup; no gating by MEM_READY, ZERO or reset.
module mips_ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_wr     = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.src_b     = SRC_B_FOUR;
        ctrl.mem_gated = 1'b1;
      end
      S_DECODE:    ctrl.src_b = SRC_B_IMM_SH2;
      S_MEM_ADR: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_gated = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.rf_wr   = 1'b1;
        ctrl.wd3_sel = 1'b1;
        ctrl.done    = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.ior_d     = 1'b1;
        ctrl.mem_wr    = 1'b1;
        ctrl.done      = 1'b1;
        ctrl.mem_gated = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.src_a  = 1'b1;
        ctrl.src_b  = SRC_B_REG;
        ctrl.alu_op = ALU_OP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl.rf_wr  = 1'b1;
        ctrl.a3_sel = 1'b1;
        ctrl.done   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.src_a  = 1'b1;
        ctrl.alu_op = ALU_OP_SUB;
        ctrl.pc_src = PC_SRC_ALU_OUT;
        ctrl.branch = 1'b1;
        ctrl.done   = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl.src_a = 1'b1;
        ctrl.src_b = SRC_B_IMM;
      end
      S_ADDI_WB: begin
        ctrl.rf_wr = 1'b1;
        ctrl.done  = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PC_SRC_JUMP;
        ctrl.pc_write = 1'b1;
        ctrl.done     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_mips_control_fsm.sv
// Multi-cycle MIPS sequencer: fetch/decode/execute/mem/writeback with MEM_READY wait states.
// Optional MIPS_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multi_cycle_mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_WIDTH = 6
) (
  input logic                          CLK,
  input logic                          RST,
  multi_cycle_mips_control_fsm_if.master bus
);

  state_t state;
  state_t dec_state;
  ctrl_t  ctrl;
  logic   illegal_q;
  logic   mem_ok;
  logic   instr_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (bus.MEM_READY) state <= S_DECODE;
        S_DECODE: begin
          case (bus.OP_CODE)
            OPC_WIDTH'(OPC_RTYPE): state <= S_EXECUTE;
            OPC_WIDTH'(OPC_LW),
            OPC_WIDTH'(OPC_SW):    state <= S_MEM_ADR;
            OPC_WIDTH'(OPC_BEQ):   state <= S_BRANCH;
            OPC_WIDTH'(OPC_ADDI):  state <= S_ADDI_EXEC;
            OPC_WIDTH'(OPC_J):     state <= S_JUMP;
            default: begin
              state     <= S_ILLEGAL;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_MEM_ADR: begin
          // Opcode is held in the IR, so it still selects load vs store here.
          if (bus.OP_CODE == OPC_WIDTH'(OPC_SW))      state <= S_MEM_WRITE;
          else if (bus.OP_CODE == OPC_WIDTH'(OPC_LW)) state <= S_MEM_READ;
          else begin
            state     <= S_ILLEGAL;
            illegal_q <= 1'b1;
          end
        end
        S_MEM_READ:  if (bus.MEM_READY) state <= S_MEM_WB;
        S_MEM_WRITE: if (bus.MEM_READY) state <= S_FETCH;
        S_EXECUTE:   state <= S_ALU_WB;
        S_ADDI_EXEC: state <= S_ADDI_WB;
        S_MEM_WB, S_ALU_WB, S_BRANCH, S_ADDI_WB, S_JUMP:
                     state <= S_FETCH;
        S_ILLEGAL:   state <= S_ILLEGAL;
        default: begin
          state     <= S_ILLEGAL;
          illegal_q <= 1'b1;
        end
      endcase
    end
  end

  // While in reset the muxes already present FETCH settings.
  assign dec_state = RST ? S_FETCH : state;

  mips_ctrl_out_decode u_out_decode (
    .state (dec_state),
    .ctrl  (ctrl)
  );

  assign mem_ok     = ~ctrl.mem_gated | bus.MEM_READY;
  assign instr_done = ~RST & ctrl.done & mem_ok;

  assign bus.PC_EN            = ~RST & ((ctrl.pc_write & mem_ok) | (ctrl.branch & bus.ZERO));
  assign bus.IR_WR_EN         = ~RST & ctrl.ir_wr & mem_ok;
  assign bus.DATA_MEM_WR_EN   = ~RST & ctrl.mem_wr;
  assign bus.REG_FILE_WR_EN   = ~RST & ctrl.rf_wr;
  assign bus.INSTR_DONE       = instr_done;
  assign bus.IOR_D_SEL        = ctrl.ior_d;
  assign bus.REG_FILE_WD3_SEL = ctrl.wd3_sel;
  assign bus.REG_FILE_A3_SEL  = ctrl.a3_sel;
  assign bus.ALU_SRC_A_SEL    = ctrl.src_a;
  assign bus.ALU_SRC_B_SEL    = ctrl.src_b;
  assign bus.ALU_OP           = ctrl.alu_op;
  assign bus.PC_SRC_SEL       = ctrl.pc_src;
  assign bus.ILLEGAL_OP       = illegal_q;

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] retired_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else if (state != S_ILLEGAL) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign bus.CYCLE_COUNT   = cycle_cnt;
  assign bus.INSTR_RETIRED = retired_cnt;
`endif

endmodule

// File: doc/multi_cycle_mips_control_fsm.md
Name: multi_cycle_mips_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the MIPS core. It replaces the single-cycle main decoder and walks each instruction through fetch, decode, execute, memory and writeback over several clocks. The unified instruction/data memory has a MEM_READY wait-state handshake. Supported instructions: R-type, lw, sw, beq, addi, j. Unknown opcodes trap to a sticky illegal state.

Parameters:
OPC_WIDTH, 6, opcode field width (instr[31:26])

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
OP_CODE  in  6  opcode from the instruction register
ZERO  in  1  ALU zero flag
MEM_READY  in  1  memory access completes this cycle
PC_EN  out  1  PC load enable = PC_WRITE | (BRANCH & ZERO)
IOR_D_SEL  out  1  memory address: 0 = PC, 1 = ALU_OUT
IR_WR_EN  out  1  instruction register load
DATA_MEM_WR_EN  out  1  memory write
REG_FILE_WR_EN  out  1  register file write
REG_FILE_WD3_SEL  out  1  0 = ALU_OUT, 1 = memory data
REG_FILE_A3_SEL  out  1  0 = rt, 1 = rd
ALU_SRC_A_SEL  out  1  0 = PC, 1 = reg A
ALU_SRC_B_SEL  out  2  00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
ALU_OP  out  2  00 = add, 01 = sub, 10 = funct-decoded
PC_SRC_SEL  out  2  00 = ALU result, 01 = ALU_OUT, 10 = jump target
INSTR_DONE  out  1  one-cycle pulse in the final cycle of each instruction
ILLEGAL_OP  out  1  sticky; set on an unknown opcode

Behaviour:
- Single clock CLK. Synchronous active-high RST. 4-bit state register.
- Reset: state = FETCH, ILLEGAL_OP = 0. Every enable (PC_EN, IR_WR_EN, DATA_MEM_WR_EN, REG_FILE_WR_EN, INSTR_DONE) is forced 0 while RST = 1. Muxes show FETCH values.
- A reset asserted mid-instruction aborts it. No write enable is asserted in that cycle.
- Outputs are Moore decodes of state. Exceptions: PC_EN depends on ZERO; FETCH and memory states gate their enables with MEM_READY. Every output not listed for a state is 0 (never x).
- States and transitions:
  - FETCH: IOR_D = 0, SRC_A = 0, SRC_B = 01, ALU_OP = 00, PC_SRC = 00.
    - IR_WR_EN = PC_WRITE = MEM_READY.
    - Stays in FETCH while MEM_READY = 0, else goes to DECODE.
  - DECODE: SRC_A = 0, SRC_B = 11, ALU_OP = 00 (branch target precompute). Next state by opcode:
    - 000000 -> EXECUTE
    - 100011 / 101011 -> MEM_ADR
    - 000100 -> BRANCH
    - 001000 -> ADDI_EXEC
    - 000010 -> JUMP
    - other -> ILLEGAL
  - MEM_ADR: SRC_A = 1, SRC_B = 10, ALU_OP = 00. Goes to MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ: IOR_D = 1. Waits for MEM_READY, then goes to MEM_WB.
  - MEM_WB: A3 = 0, WD3 = 1, REG_FILE_WR_EN = 1, INSTR_DONE = 1. Goes to FETCH.
  - MEM_WRITE: IOR_D = 1, DATA_MEM_WR_EN = 1, held until MEM_READY. INSTR_DONE = MEM_READY. Goes to FETCH on MEM_READY.
  - EXECUTE: SRC_A = 1, SRC_B = 00, ALU_OP = 10. Goes to ALU_WB.
  - ALU_WB: A3 = 1, WD3 = 0, REG_FILE_WR_EN = 1, INSTR_DONE = 1. Goes to FETCH.
  - BRANCH: SRC_A = 1, SRC_B = 00, ALU_OP = 01, PC_SRC = 01, BRANCH = 1, so PC_EN = ZERO. INSTR_DONE = 1. Goes to FETCH.
  - ADDI_EXEC: SRC_A = 1, SRC_B = 10, ALU_OP = 00. Goes to ADDI_WB.
  - ADDI_WB: A3 = 0, WD3 = 0, REG_FILE_WR_EN = 1, INSTR_DONE = 1. Goes to FETCH.
  - JUMP: PC_SRC = 10, PC_WRITE = 1, INSTR_DONE = 1. Goes to FETCH.
  - ILLEGAL: ILLEGAL_OP = 1, all enables 0. Stays in ILLEGAL until RST.
- Latency in cycles with MEM_READY held at 1: lw 5; sw, R-type and addi 4; beq and j 3. Each cycle of MEM_READY = 0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Unused state encodings go to ILLEGAL.

Optional Feature:
MIPS_PERF_CNT_EN
- When defined: adds outputs CYCLE_COUNT[31:0] and INSTR_RETIRED[31:0].
  - CYCLE_COUNT increments every non-reset cycle.
  - INSTR_RETIRED increments on INSTR_DONE.
  - Both clear on RST and wrap 0xFFFFFFFF -> 0.
  - Both freeze in ILLEGAL.
- When undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package mips_ctrl_pkg contains:
  - opcode localparams (OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J)
  - state enum typedef
  - ALU_SRC_B, PC_SRC and ALU_OP select encodings
- One natural sub-module: mips_ctrl_out_decode, a combinational state -> control-vector lookup. Enable gating (MEM_READY, ZERO, RST) stays in the top.

Test Plan:
- RST = 1 for 2 cycles, then 0 with MEM_READY = 1 and OP_CODE = 000000 -> IR_WR_EN = 1 in cycle 1. REG_FILE_WR_EN = 1 with A3 = 1 in cycle 4, together with INSTR_DONE.
- lw (100011) with MEM_READY low for 3 cycles in MEM_READ -> IOR_D = 1 held for 4 cycles. MEM_WB follows. Total 8 cycles.
- beq (000100): ZERO = 1 -> PC_EN = 1 and PC_SRC = 01 in cycle 3. Repeat with ZERO = 0 -> PC_EN = 0, next state FETCH.
- sw with MEM_READY = 0 for 2 cycles -> DATA_MEM_WR_EN held for 3 cycles and REG_FILE_WR_EN never 1. j -> PC_SRC = 10 and PC_EN = 1 in cycle 3.
- OP_CODE = 111111 -> ILLEGAL_OP = 1 from cycle 3 and all enables stay 0 for 10 cycles. RST -> back in FETCH with ILLEGAL_OP = 0.
- RST asserted in EXECUTE of an R-type -> no REG_FILE_WR_EN pulse; FETCH follows. With MIPS_PERF_CNT_EN, after 3 addi instructions INSTR_RETIRED = 3 and CYCLE_COUNT = 12.
